// File: rtl/input_keypad_scanner_pkg.sv
// Shared constants and types for the 4x4 keypad scanner and its debounce cells.
package input_keypad_scanner_pkg;

    localparam int INPUT_ROWS = 4;
    localparam int INPUT_COLS = 4;
    localparam int INPUT_KEYS = INPUT_ROWS * INPUT_COLS;
    localparam int DEB_W      = 4;

    typedef logic [DEB_W-1:0] deb_cnt_t;
    typedef logic [1:0]       row_idx_t;

    // Key index of the switch at row r / column c.
    function automatic int key_index(input int r, input int c);
        return INPUT_COLS * r + c;
    endfunction

endpackage

// File: rtl/input_keypad_scanner_if.sv
// Keypad matrix and debounced-key bundle; master = scanner side, slave = matrix/consumer side.
interface input_keypad_scanner_if;
    import input_keypad_scanner_pkg::*;

    logic [INPUT_ROWS-1:0] row_n;
    logic [INPUT_COLS-1:0] col_n;
    logic [INPUT_KEYS-1:0] key;
    logic                  frame_done;

    modport master (output row_n, output key, output frame_done, input col_n);
    modport slave  (input row_n, input key, input frame_done, output col_n);

endinterface

// File: rtl/input_keypad_scanner_debounce_cell.sv
// One key's debounced level: the level toggles after DEB_CNT consecutive disagreeing frames.
module input_debounce_cell
    import input_keypad_scanner_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic frame_valid_i,
    input  logic frame_bit_i,
    output logic key_o
);

    localparam deb_cnt_t CNT_LAST = deb_cnt_t'(DEB_CNT - 1);

    deb_cnt_t cnt_q, cnt_d;
    logic     key_q, key_d;

    always_comb begin
        cnt_d = cnt_q;
        key_d = key_q;
        if (frame_valid_i) begin
            if (frame_bit_i == key_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                key_d = ~key_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
            key_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/input_keypad_scanner.sv
// 4x4 keypad scanner: row rotation, column synchronizer, frame assembly and per-key debounce.
// Optional build macro INPUT_GHOST_REJECT_EN discards frames with more than two keys down.
module input_keypad_scanner
    import input_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input_keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    row_idx_t              row_q, row_d;
    logic [INPUT_ROWS-1:0] row_n_q, row_n_d;
    logic [INPUT_COLS-1:0] sync1_q, sync2_q;
    logic [INPUT_KEYS-1:0] raw_q, raw_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sample;
    logic                  frame_eval;
    logic                  frame_valid;
    logic [INPUT_KEYS-1:0] key_w;

    assign sample     = (div_q == DIV_LAST);
    assign frame_eval = sample && (row_q == row_idx_t'(INPUT_ROWS - 1));

    always_comb begin
        div_d   = sample ? '0 : div_q + 1'b1;
        row_d   = sample ? row_q + 1'b1 : row_q;
        row_n_d = sample ? {row_n_q[INPUT_ROWS-2:0], row_n_q[INPUT_ROWS-1]} : row_n_q;
        raw_d   = raw_q;
        if (sample) begin
            raw_d[key_index(int'(row_q), 0) +: INPUT_COLS] = ~sync2_q;
        end
        frame_done_d = frame_eval;
    end

    // On the row-3 sample edge raw_d already carries the current row, so it is the whole frame.
`ifdef INPUT_GHOST_REJECT_EN
    assign frame_valid = frame_eval && ($countones(raw_d) <= 2);
`else
    assign frame_valid = frame_eval;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q        <= '0;
            row_q        <= '0;
            row_n_q      <= 4'b1110;
            sync1_q      <= 4'b1111;
            sync2_q      <= 4'b1111;
            raw_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            row_n_q      <= row_n_d;
            sync1_q      <= kp.col_n;
            sync2_q      <= sync1_q;
            raw_q        <= raw_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar i = 0; i < INPUT_KEYS; i++) begin : g_deb
        input_debounce_cell #(.DEB_CNT(DEB_CNT)) u_cell (
            .Clock        (Clock),
            .Reset        (Reset),
            .frame_valid_i(frame_valid),
            .frame_bit_i  (raw_d[i]),
            .key_o        (key_w[i])
        );
    end

    assign kp.row_n      = row_n_q;
    assign kp.key        = key_w;
    assign kp.frame_done = frame_done_q;

endmodule

// File: tb/tb_input_keypad_scanner.sv
// Directed bench for input_keypad_scanner with SCAN_DIV=4, DEB_CNT=2 and an ideal switch matrix.
module tb_input_keypad_scanner;

    logic        Clock;
    logic        Reset;
    logic [15:0] pressed;
    logic [3:0]  cn;
    int          cyc;
    int          passed;
    int          total;

    input_keypad_scanner_if kp_if ();

    input_keypad_scanner #(.SCAN_DIV(4), .DEB_CNT(2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .kp   (kp_if.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Pressed switch at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cn = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !kp_if.row_n[r]) cn[c] = 1'b0;
    end
    assign kp_if.col_n = cn;

    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        pressed = 16'h0000;
        do_reset();
        total++; if (kp_if.row_n !== 4'b1110) $display("FAIL reset_row_n got %b want 1110", kp_if.row_n); else passed++;
        total++; if (kp_if.key !== 16'h0000) $display("FAIL reset_key got %h want 0000", kp_if.key); else passed++;
        total++; if (kp_if.frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", kp_if.frame_done); else passed++;
        pressed = 16'h0200;
        repeat (36) step();
        total++; if (kp_if.key !== 16'h0200) $display("FAIL pre_reset_key got %h want 0200", kp_if.key); else passed++;
        pressed = 16'h0000;
        do_reset();
        total++; if (kp_if.row_n !== 4'b1110) $display("FAIL midscan_reset_row_n got %b want 1110", kp_if.row_n); else passed++;
        total++; if (kp_if.key !== 16'h0000) $display("FAIL midscan_reset_key got %h want 0000", kp_if.key); else passed++;
        total++; if (kp_if.frame_done !== 1'b0) $display("FAIL midscan_reset_fd got %b want 0", kp_if.frame_done); else passed++;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (kp_if.frame_done !== (k == 16))
                $display("FAIL first_frame_done cyc=%0d got %b want %b", k, kp_if.frame_done, (k == 16));
            else passed++;
        end
    endtask

    task automatic test_single_press();
        logic [15:0] exp;
        do_reset();
        pressed = 16'h0200;
        for (int k = 1; k <= 84; k++) begin
            step();
            if (k == 48) pressed = 16'h0000;
            exp = (k >= 32 && k < 80) ? 16'h0200 : 16'h0000;
            total++;
            if (kp_if.key !== exp) $display("FAIL press_key9 cyc=%0d got %h want %h", k, kp_if.key, exp);
            else passed++;
            total++;
            if (kp_if.frame_done !== (k % 16 == 0))
                $display("FAIL press_fd cyc=%0d got %b want %b", k, kp_if.frame_done, (k % 16 == 0));
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic [15:0] exp;
        do_reset();
        pressed = 16'h0020;
        for (int k = 1; k <= 68; k++) begin
            step();
            if (k == 16) pressed = 16'h0000;
            if (k == 32) pressed = 16'h0020;
            exp = (k >= 64) ? 16'h0020 : 16'h0000;
            total++;
            if (kp_if.key !== exp) $display("FAIL bounce_key5 cyc=%0d got %h want %h", k, kp_if.key, exp);
            else passed++;
        end
    endtask

    task automatic test_mid_debounce_reset();
        logic [15:0] exp;
        do_reset();
        pressed = 16'h0001;
        repeat (16) step();
        total++; if (kp_if.key !== 16'h0000) $display("FAIL middeb_pre got %h want 0000", kp_if.key); else passed++;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            step();
            exp = (k >= 32) ? 16'h0001 : 16'h0000;
            total++;
            if (kp_if.key !== exp) $display("FAIL middeb_key0 cyc=%0d got %h want %h", k, kp_if.key, exp);
            else passed++;
        end
        pressed = 16'h0000;
    endtask

    task automatic test_ghost();
        logic [15:0] exp;
        do_reset();
        pressed = 16'h0013;
        for (int k = 1; k <= 50; k++) begin
            step();
`ifdef INPUT_GHOST_REJECT_EN
            exp = 16'h0000;
`else
            exp = (k >= 32) ? 16'h0013 : 16'h0000;
`endif
            total++;
            if (kp_if.key !== exp) $display("FAIL ghost_key cyc=%0d got %h want %h", k, kp_if.key, exp);
            else passed++;
            total++;
            if (kp_if.frame_done !== (k % 16 == 0))
                $display("FAIL ghost_fd cyc=%0d got %b want %b", k, kp_if.frame_done, (k % 16 == 0));
            else passed++;
        end
        pressed = 16'h0000;
    endtask

    task automatic test_rotation();
        logic [3:0] rows [4];
        rows[0] = 4'b1110;
        rows[1] = 4'b1101;
        rows[2] = 4'b1011;
        rows[3] = 4'b0111;
        pressed = 16'h0000;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step();
            total++;
            if (kp_if.row_n !== rows[(k / 4) % 4])
                $display("FAIL rotation_row_n cyc=%0d got %b want %b", k, kp_if.row_n, rows[(k / 4) % 4]);
            else passed++;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        pressed = 16'h0000;
        cyc     = 0;
        passed  = 0;
        total   = 0;
        repeat (2) @(posedge Clock);
        #1;
        test_reset();
        test_single_press();
        test_bounce();
        test_mid_debounce_reset();
        test_ghost();
        test_rotation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
